instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Fetch sequencer for the 16-bit core; the control side of the program counter.
- Reads the current PC value and issues one instruction-memory read per instruction. It presents the returned word to decode with a valid/ready handshake.
- Drives the PC's enable/op/offset inputs: advance by 1, skip (+2), or branch (+offset).
- Handles branch redirects, including discarding a memory response already in flight.

Parameters:
- ADDR_W, 16, PC / memory address width
- DATA_W, 16, instruction width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pc_in  in  ADDR_W  current PC value (program counter output)
- PC_enable  out  1  PC update strobe, registered
- PC_op  out  2  00 hold, 01 +1, 10 +2, 11 +offset; registered
- offset  out  ADDR_W  branch offset, two's complement; registered
- mem_req  out  1  read request, one-cycle pulse
- mem_addr  out  ADDR_W  read address, valid while mem_req=1
- mem_rdata  in  DATA_W  read data, valid while mem_rvalid=1
- mem_rvalid  in  1  one-cycle response strobe; arrives ≥1 cycle after mem_req; at most one read outstanding
- instr_out  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address instr_out was fetched from
- instr_valid  out  1  instr_out/instr_pc valid
- instr_ready  in  1  decode accepts when instr_valid & instr_ready
- skip_take  in  1  sampled with the accept; advance PC by 2 instead of 1
- branch_take  in  1  one-cycle redirect request from execute
- branch_offset  in  ADDR_W  offset applied with branch_take

Behaviour:
- Reset (async): state=IDLE, and all outputs are 0.
  - This covers PC_enable, PC_op, offset, mem_req, mem_addr, instr_out, instr_pc and instr_valid.
  - drop_pending is also cleared to 0.
  - Reset mid-transaction abandons it; a late mem_rvalid in IDLE is ignored.
- States: IDLE, REQ, WAIT, HOLD, ADV, DRAIN.
- IDLE: moves to REQ on the first clock after reset deasserts.
- REQ: mem_req=1 and mem_addr=pc_in for exactly one cycle, then WAIT.
- WAIT: on mem_rvalid, register instr_out=mem_rdata, instr_pc=pc_in and instr_valid=1, then go to HOLD. Wait is unbounded.
- HOLD:
  - instr_valid, instr_out and instr_pc stay stable until the accept.
  - On accept: instr_valid<=0, PC_enable<=1, PC_op<=(skip_take ? 10 : 01), then go to ADV.
- ADV:
  - PC_enable is high for this one cycle only, so the PC updates at the end of ADV.
  - PC_enable<=0 and PC_op<=00 on exit.
  - Next state is DRAIN if drop_pending=1, else REQ. REQ therefore always sees the updated pc_in.
- DRAIN: wait for mem_rvalid, discard its data, clear drop_pending, then go to REQ. No mem_req is issued while in DRAIN.
- Branch (branch_take=1 in REQ, WAIT or HOLD):
  - Registered outputs: PC_enable<=1, PC_op<=11, offset<=branch_offset, instr_valid<=0, then go to ADV.
  - Branch has priority over a same-cycle accept in HOLD, so the accept is void.
  - In REQ the request is still issued this cycle, so drop_pending<=1.
  - In WAIT without mem_rvalid the response is still in flight, so drop_pending<=1.
  - In WAIT with mem_rvalid in the same cycle, the response is discarded and drop_pending stays 0.
  - branch_take is ignored in IDLE, ADV and DRAIN; execute does not assert it there.
- offset holds its last branch value. It is meaningful only when PC_op=11.
- Latency: memory latency L (cycles from mem_req to mem_rvalid).
  - mem_req to instr_valid = L+1 cycles.
  - Accept to the next mem_req = 2 cycles (ADV, then REQ).
- Address arithmetic belongs to the PC; wrap-around (0xFFFF+1 = 0x0000) is not special-cased here.

Decomposition:
- Shared package (cpu_pkg):
  - PC_op encodings PC_HOLD=2'b00, PC_INC1=2'b01, PC_INC2=2'b10, PC_BRANCH=2'b11.
  - ADDR_W/DATA_W defaults.
  - Fetch state enum.
- No sub-module; a single FSM plus an output register bank.

Test Plan:
- Reset, memory returns 0x1234 at L=1, decode always ready:
  - mem_addr=0x0000; instr_valid with instr_out=0x1234 and instr_pc=0x0000.
  - PC_enable=1, PC_op=01 for exactly one cycle.
  - Next mem_addr=0x0001.
- instr_ready held 0 for 5 cycles in HOLD: instr_valid, instr_out and instr_pc stay stable, no mem_req, PC_enable=0; on release, exactly one +1 advance.
- Accept with skip_take=1 at pc=0x0010: PC_op=10, and the next mem_addr=0x0012.
- branch_take with branch_offset=0xFFFC in WAIT, L=3:
  - Response discarded; instr_valid stays 0.
  - PC_op=11, offset=0xFFFC.
  - No mem_req until the stale mem_rvalid arrives; the next mem_addr is the redirected PC.
- branch_take coinciding with mem_rvalid in WAIT, and separately with an accept in HOLD:
  - No drop_pending and no DRAIN cycle.
  - Only the branch update (PC_op=11) is issued; no +1.
- Reset asserted asynchronously while in WAIT: all outputs are 0 immediately; the late mem_rvalid is ignored; fetch restarts at pc_in=0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: PC update opcodes, default widths
// and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC1   = 2'b01;
    localparam logic [1:0] PC_INC2   = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ADV   = 3'd4,
        ST_DRAIN = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: one memory read per instruction, hands the word to decode
// and steers the PC (+1, +2 or +offset), dropping responses made stale by a branch.
module instr_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              PC_enable,
    output logic [1:0]        PC_op,
    output logic [ADDR_W-1:0] offset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              skip_take,
    input  logic              branch_take,
    input  logic [ADDR_W-1:0] branch_offset
);

    // Decode handshake: a word transfers on a clock where instr_valid & instr_ready;
    // once raised, instr_valid, instr_out and instr_pc hold until that transfer.
    fetch_state_e      state_q, state_d;
    logic              drop_q, drop_d;
    logic              pc_en_q, pc_en_d;
    logic [1:0]        pc_op_q, pc_op_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;

    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        pc_en_d       = pc_en_q;
        pc_op_d       = pc_op_q;
        offset_d      = offset_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ, ST_WAIT, ST_HOLD: begin
                if (branch_take) begin
                    pc_en_d       = 1'b1;
                    pc_op_d       = PC_BRANCH;
                    offset_d      = branch_offset;
                    instr_valid_d = 1'b0;
                    state_d       = ST_ADV;
                    // A request issued but not yet answered must be swallowed later.
                    if (state_q == ST_REQ || (state_q == ST_WAIT && !mem_rvalid)) begin
                        drop_d = 1'b1;
                    end
                end else if (state_q == ST_REQ) begin
                    state_d = ST_WAIT;
                end else if (state_q == ST_WAIT) begin
                    if (mem_rvalid) begin
                        instr_out_d   = mem_rdata;
                        instr_pc_d    = pc_in;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_en_d       = 1'b1;
                    pc_op_d       = skip_take ? PC_INC2 : PC_INC1;
                    state_d       = ST_ADV;
                end
            end
            ST_ADV: begin
                pc_en_d = 1'b0;
                pc_op_d = PC_HOLD;
                // A stale response landing during ADV already settles the drop.
                if (drop_q && !mem_rvalid) begin
                    state_d = ST_DRAIN;
                end else begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            drop_q        <= 1'b0;
            pc_en_q       <= 1'b0;
            pc_op_q       <= PC_HOLD;
            offset_q      <= '0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            pc_en_q       <= pc_en_d;
            pc_op_q       <= pc_op_d;
            offset_q      <= offset_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Address is taken live in REQ so it reflects the PC update made during ADV.
    assign mem_req     = (state_q == ST_REQ);
    assign mem_addr    = (state_q == ST_REQ) ? pc_in : '0;
    assign PC_enable   = pc_en_q;
    assign PC_op       = pc_op_q;
    assign offset      = offset_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a PC model and a fixed-latency memory.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_in;
    logic        PC_enable;
    logic [1:0]  PC_op;
    logic [15:0] offset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        skip_take;
    logic        branch_take;
    logic [15:0] branch_offset;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 1;
    logic [15:0] exp_q[$];

    instr_fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .PC_enable    (PC_enable),
        .PC_op        (PC_op),
        .offset       (offset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .skip_take    (skip_take),
        .branch_take  (branch_take),
        .branch_offset(branch_offset)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0000) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // Environment: PC register and memory with latency lat.
    initial begin
        logic        req_s, en_s;
        logic [15:0] addr_s, off_s, pend_addr;
        logic [1:0]  op_s;
        int          cnt;
        cnt        = 0;
        pend_addr  = '0;
        pc_in      = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            req_s  = mem_req;
            addr_s = mem_addr;
            en_s   = PC_enable;
            op_s   = PC_op;
            off_s  = offset;
            @(posedge clk);
            #1;
            if (reset) pc_in = '0;
            else if (en_s) begin
                case (op_s)
                    2'b01:   pc_in = pc_in + 16'd1;
                    2'b10:   pc_in = pc_in + 16'd2;
                    2'b11:   pc_in = pc_in + off_s;
                    default: pc_in = pc_in;
                endcase
            end
            mem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(pend_addr);
                end
            end
            if (req_s) begin
                pend_addr = addr_s;
                if (lat == 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(addr_s);
                end else begin
                    cnt = lat - 1;
                end
            end
        end
    end

    // driver / checking tasks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input logic [15:0] exp);
        int n = 0;
        nxt();
        while (!mem_req && n < 40) begin
            nxt();
            n++;
        end
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_addr"}, mem_addr, exp);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        nxt();
        while (!instr_valid && n < 40) begin
            nxt();
            n++;
        end
        check({tag, "_valid"}, instr_valid, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_en"}, PC_enable, 0);
        check({tag, "_pc_op"}, PC_op, 0);
        check({tag, "_offset"}, offset, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_ivalid"}, instr_valid, 0);
        check({tag, "_iout"}, instr_out, 0);
        check({tag, "_ipc"}, instr_pc, 0);
    endtask

    initial begin
        int          bad;
        logic [15:0] s_out, s_pc, a;
        reset         = 1'b1;
        instr_ready   = 1'b1;
        skip_take     = 1'b0;
        branch_take   = 1'b0;
        branch_offset = '0;
        lat           = 1;

        // Test 1: reset state, first fetch at L=1
        repeat (2) nxt();
        check_all_zero("rst");
        reset = 1'b0;
        wait_req("t1_first", 16'h0000);
        wait_valid("t1");
        check("t1_iout", instr_out, 16'h1234);
        check("t1_ipc", instr_pc, 16'h0000);
        nxt();
        check("t1_adv_en", PC_enable, 1);
        check("t1_adv_op", PC_op, 2'b01);
        wait_req("t1_next", 16'h0001);
        check("t1_en_once", PC_enable, 0);

        // Test 2: decode stalls 5 cycles in HOLD
        instr_ready = 1'b0;
        wait_valid("t2");
        check("t2_iout", instr_out, 16'hA5A4);
        check("t2_ipc", instr_pc, 16'h0001);
        s_out = instr_out;
        s_pc  = instr_pc;
        bad   = 0;
        repeat (5) begin
            nxt();
            if (!instr_valid || instr_out != s_out || instr_pc != s_pc || mem_req || PC_enable) bad++;
        end
        check("t2_hold_stable", bad, 0);
        instr_ready = 1'b1;
        nxt();
        check("t2_adv_en", PC_enable, 1);
        check("t2_adv_op", PC_op, 2'b01);
        wait_req("t2_next", 16'h0002);
        check("t2_en_once", PC_enable, 0);

        // Test 3: sequential walk to 0x0010, then skip
        for (int i = 3; i <= 16; i++) exp_q.push_back(i[15:0]);
        while (exp_q.size() > 0) begin
            a = exp_q.pop_front();
            wait_req($sformatf("t3_seq_%0h", a), a);
        end
        skip_take = 1'b1;
        wait_valid("t3");
        nxt();
        check("t3_skip_en", PC_enable, 1);
        check("t3_skip_op", PC_op, 2'b10);
        skip_take = 1'b0;
        lat       = 3;
        wait_req("t3_after_skip", 16'h0012);

        // Test 4: branch in WAIT with response in flight, L=3
        nxt();
        branch_take   = 1'b1;
        branch_offset = 16'hFFFC;
        nxt();
        branch_take = 1'b0;
        check("t4_br_en", PC_enable, 1);
        check("t4_br_op", PC_op, 2'b11);
        check("t4_br_off", offset, 16'hFFFC);
        check("t4_adv_noreq", mem_req, 0);
        check("t4_adv_ivalid", instr_valid, 0);
        nxt();
        check("t4_drain_noreq", mem_req, 0);
        check("t4_drain_ivalid", instr_valid, 0);
        check("t4_drain_en", PC_enable, 0);
        nxt();
        check("t4_redir_req", mem_req, 1);
        check("t4_redir_addr", mem_addr, 16'h000E);
        check("t4_redir_ivalid", instr_valid, 0);

        // Test 5a: branch coincides with mem_rvalid in WAIT
        repeat (3) nxt();
        branch_take   = 1'b1;
        branch_offset = 16'h0020;
        nxt();
        branch_take = 1'b0;
        lat         = 1;
        check("t5a_br_en", PC_enable, 1);
        check("t5a_br_op", PC_op, 2'b11);
        check("t5a_br_off", offset, 16'h0020);
        check("t5a_ivalid", instr_valid, 0);
        nxt();
        check("t5a_nodrain_req", mem_req, 1);
        check("t5a_nodrain_addr", mem_addr, 16'h002E);

        // Test 5b: branch coincides with accept in HOLD
        wait_valid("t5b");
        check("t5b_iout", instr_out, 16'hA58B);
        check("t5b_ipc", instr_pc, 16'h002E);
        branch_take   = 1'b1;
        branch_offset = 16'h0100;
        nxt();
        branch_take = 1'b0;
        lat         = 3;
        check("t5b_br_en", PC_enable, 1);
        check("t5b_br_op", PC_op, 2'b11);
        check("t5b_br_off", offset, 16'h0100);
        check("t5b_ivalid", instr_valid, 0);
        nxt();
        check("t5b_nodrain_req", mem_req, 1);
        check("t5b_nodrain_addr", mem_addr, 16'h012E);
        check("t5b_en_once", PC_enable, 0);

        // Test 6: async reset during WAIT, stale response ignored
        nxt();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t6_async");
        nxt();
        nxt();
        reset = 1'b0;
        nxt();
        check("t6_restart_req", mem_req, 1);
        check("t6_restart_addr", mem_addr, 16'h0000);
        check("t6_stale_ivalid", instr_valid, 0);
        wait_valid("t6");
        check("t6_iout", instr_out, 16'h1234);
        check("t6_ipc", instr_pc, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
